// File: rtl/tagged_latency_pipe.sv
// Small synchronous FIFO with clear; head is visible combinationally on rd_dat.
// Latency: write visible at head one cycle after push.
// Backpressure: caller must not push when full nor pop when empty.
module tlp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [W-1:0]     wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [W-1:0]     rd_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_rdy) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_vld, rd_rdy})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Tagged multi-outstanding fixed-latency timer: each start returns its tag on done.
// Latency: cfg_latency active edges (0 = pulse right after accept); stalls extend 1:1.
// Backpressure: start_ready drops on stall, flush, or MAX_INFLIGHT outstanding.
module tagged_latency_pipe #(
    parameter int MAX_LATENCY  = 16,
    parameter int LAT_W        = 5,
    parameter int TAG_W        = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LAT_W-1:0] cfg_latency,
    input  logic             start,
    input  logic [TAG_W-1:0] start_tag,
    output logic             start_ready,
    input  logic             stall,
    input  logic             flush,
    output logic             done,
    output logic [TAG_W-1:0] done_tag,
    output logic             busy,
    output logic [CNT_W-1:0] inflight,
    output logic [LAT_W-1:0] lat_active,
    output logic             cfg_err
);
    localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(MAX_LATENCY);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [LAT_W-1:0] due;
    } entry_t;

    // Free-running count of active edges; entries hold the tick they complete on.
    // Its period (2^LAT_W) exceeds MAX_LATENCY, so due never aliases.
    logic [LAT_W-1:0] tick;
    entry_t           push_e;
    entry_t           head_e;
    logic             head_vld;
    logic             cfg_over;
    logic [LAT_W-1:0] cfg_clamped;
    logic             fresh;
    logic [LAT_W-1:0] le;
    logic             accept;
    logic             head_due;
    logic             pop;
    logic             push;
    logic             bypass;

    assign start_ready = !stall && !flush && (inflight < CNT_W'(MAX_INFLIGHT));
    assign accept      = start && start_ready;
    assign cfg_over    = (cfg_latency > MAX_LAT);
    assign cfg_clamped = cfg_over ? MAX_LAT : cfg_latency;
    assign fresh       = (inflight == '0);
    assign le          = fresh ? cfg_clamped : lat_active;

    assign head_due = head_vld && (head_e.due == tick);
    assign pop      = !stall && !flush && head_due;
    // Zero latency never occupies a slot: accept and completion share the edge.
    assign push     = accept && (le != '0);
    assign bypass   = accept && (le == '0);

    assign push_e.tag = start_tag;
    assign push_e.due = tick + le;

    assign busy = (inflight != '0);

    tlp_fifo #(
        .W     (TAG_W + LAT_W),
        .DEPTH (MAX_INFLIGHT),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .wr_vld (push),
        .wr_dat (push_e),
        .rd_rdy (pop),
        .rd_vld (head_vld),
        .rd_dat (head_e),
        .count  (inflight)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            done       <= 1'b0;
            done_tag   <= '0;
            lat_active <= '0;
            cfg_err    <= 1'b0;
            tick       <= '0;
        end else if (flush || stall) begin
            done     <= 1'b0;
            done_tag <= '0;
        end else begin
            tick     <= tick + 1'b1;
            done     <= pop || bypass;
            done_tag <= pop ? head_e.tag : (bypass ? start_tag : '0);
            if (accept) begin
                lat_active <= le;
                if (fresh && cfg_over) begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end
endmodule
